// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back arbiter slice.
//   wb_entry_t            : one buffered load response (destination + data).
//   WB_FIFO_DEPTH_DEFAULT : default load-response buffer depth.
//   rd_onehot()           : register-index decoder. x0 maps to no bit, so x0
//                           can never appear in the pending scoreboard.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    logic [31:0] v;
    v = 32'd0;
    if (rd != 5'd0) v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles every non-clock/reset signal of wb_arbiter.
//   alu_valid/alu_rd/alu_data          : pipeline write-back request
//   ld_issue_valid/ld_issue_rd         : load issued to memory
//   ld_rsp_valid/ld_rsp_ready/rd/data  : load response handshake
//   rf_we/rf_rd/rf_data                : register-file write port
//   pending                            : in-flight load destination bitmap
// Modports:
//   master : the pipeline / memory side (drives requests, sees results)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface wb_arbiter_if;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;

  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [4:0]  ld_rsp_rd;
  logic [31:0] ld_rsp_data;

  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  logic [31:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    input  ld_rsp_ready,
    input  rf_we, rf_rd, rf_data,
    input  pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    output ld_rsp_ready,
    output rf_we, rf_rd, rf_data,
    output pending
  );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t used to buffer load responses.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push         : write push_entry (honoured when not full, or when full
//                  and popping in the same cycle)
//   push_entry   : entry to write
//   pop          : remove the head entry (ignored when empty)
//   head         : current head entry (valid when !empty)
//   full, empty  : occupancy flags
// Parameter DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges the never-stalling pipeline write-back and buffered load responses
// onto the single register-file write port, and tracks in-flight load
// destinations in a 32-bit pending scoreboard for the hazard unit.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (clears outputs, FIFO, pending)
//   bus     : wb_arbiter_if.slave (pipeline, load issue/response, rf write
//             port, pending bitmap)
// Parameter FIFO_DEPTH : load-response buffer entries (power of two, >= 2).
// Build option WB_BYPASS_EN : when defined, a response arriving with the FIFO
//   empty and no ALU write is written straight through (1-cycle latency);
//   otherwise every response goes through the FIFO (2-cycle minimum).
// Priority: ALU > FIFO head > bypassed response. Writes to x0 are dropped,
// but a dropped load still consumes its FIFO entry.
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);

  wb_entry_t   fifo_head;
  wb_entry_t   rsp_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        bypass;

  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        ld_done;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;
  logic [31:0] pending_nxt;

  logic        rf_we_q;
  logic [4:0]  rf_rd_q;
  logic [31:0] rf_data_q;
  logic [31:0] pending_q;

  assign rsp_entry = '{rd: bus.ld_rsp_rd, data: bus.ld_rsp_data};

  // Ready depends on occupancy only, so a full FIFO refuses a response even
  // in a cycle where it is also being drained.
  assign bus.ld_rsp_ready = !fifo_full;

  always_comb begin
    pop = !bus.alu_valid && !fifo_empty;
`ifdef WB_BYPASS_EN
    bypass = !bus.alu_valid && fifo_empty && bus.ld_rsp_valid;
`else
    bypass = 1'b0;
`endif
    push = bus.ld_rsp_valid && !fifo_full && !bypass;
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (rsp_entry),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Write-port source select.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    ld_done = 1'b0;
    wr_en   = 1'b0;
    if (bus.alu_valid) begin
      wr_rd   = bus.alu_rd;
      wr_data = bus.alu_data;
      wr_en   = 1'b1;
    end else if (pop) begin
      wr_rd   = fifo_head.rd;
      wr_data = fifo_head.data;
      ld_done = 1'b1;
      wr_en   = 1'b1;
    end else if (bypass) begin
      wr_rd   = bus.ld_rsp_rd;
      wr_data = bus.ld_rsp_data;
      ld_done = 1'b1;
      wr_en   = 1'b1;
    end
    if (wr_rd == 5'd0) wr_en = 1'b0;
  end

  // Scoreboard: a new issue to the same register overrides a retiring load,
  // since the newer load is still outstanding.
  always_comb begin
    pend_clr    = ld_done ? rd_onehot(wr_rd) : 32'd0;
    pend_set    = bus.ld_issue_valid ? rd_onehot(bus.ld_issue_rd) : 32'd0;
    pending_nxt = (pending_q & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      rf_we_q   <= wr_en;
      pending_q <= pending_nxt;
      if (wr_en) begin
        rf_rd_q   <= wr_rd;
        rf_data_q <= wr_data;
      end
    end
  end

  assign bus.rf_we   = rf_we_q;
  assign bus.rf_rd   = rf_rd_q;
  assign bus.rf_data = rf_data_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed self-checking bench for wb_arbiter (FIFO_DEPTH = 2). Load write
// latency expectations follow the WB_BYPASS_EN build option.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "_we"},   {31'd0, bus.rf_we}, 32'd1);
    check({tag, "_rd"},   {27'd0, bus.rf_rd}, {27'd0, rd});
    check({tag, "_data"}, bus.rf_data, data);
  endtask

  task automatic check_nowr(input string tag);
    check({tag, "_we"}, {31'd0, bus.rf_we}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = 5'd0;
    bus.alu_data       = 32'd0;
    bus.ld_issue_valid = 1'b0;
    bus.ld_issue_rd    = 5'd0;
    bus.ld_rsp_valid   = 1'b0;
    bus.ld_rsp_rd      = 5'd0;
    bus.ld_rsp_data    = 32'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.ld_issue_valid = 1'b1;
    bus.ld_issue_rd    = rd;
  endtask

  task automatic rsp(input logic [4:0] rd, input logic [31:0] d);
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_rd    = rd;
    bus.ld_rsp_data  = d;
  endtask

  // Present one response with no ALU traffic and an empty FIFO, then advance
  // to the cycle in which its write is visible.
  task automatic load_rsp(input logic [4:0] rd, input logic [31:0] d);
    rsp(rd, d);
    tick();
    bus.ld_rsp_valid = 1'b0;
`ifndef WB_BYPASS_EN
    check_nowr("load_queued");
    tick();
`endif
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #3;
    check_nowr("in_reset");
    check("in_reset_ready", {31'd0, bus.ld_rsp_ready}, 32'd1);
    #20;
    reset_n = 1'b1;
    tick();

    // Reset state
    check_nowr("reset");
    check("reset_rd",      {27'd0, bus.rf_rd}, 32'd0);
    check("reset_data",    bus.rf_data, 32'd0);
    check("reset_pending", bus.pending, 32'd0);
    check("reset_ready",   {31'd0, bus.ld_rsp_ready}, 32'd1);

    // Back-to-back ALU writes
    alu(5'd5, 32'h11);
    tick();
    check_wr("alu_x5", 5'd5, 32'h11);
    alu(5'd6, 32'h22);
    tick();
    check_wr("alu_x6", 5'd6, 32'h22);
    check("alu_pending", bus.pending, 32'd0);
    idle();
    tick();
    check_nowr("alu_done");

    // Single load to x7
    issue(5'd7);
    tick();
    idle();
    check("ld7_pending_set", bus.pending, 32'h80);
    load_rsp(5'd7, 32'hDEADBEEF);
    check_wr("ld7_write", 5'd7, 32'hDEADBEEF);
    check("ld7_pending_clr", bus.pending, 32'd0);
    tick();
    check_nowr("ld7_done");

    // Back-pressure: three responses during four ALU cycles
    issue(5'd10);
    tick();
    issue(5'd11);
    tick();
    issue(5'd12);
    tick();
    idle();
    check("bp_pending", bus.pending, 32'h1C00);
    alu(5'd20, 32'h200);
    rsp(5'd10, 32'hA0A0);
    tick();
    check_wr("bp_alu20", 5'd20, 32'h200);
    check("bp_ready_1", {31'd0, bus.ld_rsp_ready}, 32'd1);
    alu(5'd21, 32'h210);
    rsp(5'd11, 32'hB1B1);
    tick();
    check_wr("bp_alu21", 5'd21, 32'h210);
    check("bp_ready_full", {31'd0, bus.ld_rsp_ready}, 32'd0);
    alu(5'd22, 32'h220);
    rsp(5'd12, 32'hC2C2);
    tick();
    check_wr("bp_alu22", 5'd22, 32'h220);
    check("bp_ready_hold", {31'd0, bus.ld_rsp_ready}, 32'd0);
    alu(5'd23, 32'h230);
    tick();
    check_wr("bp_alu23", 5'd23, 32'h230);
    check("bp_pending_hold", bus.pending, 32'h1C00);
    bus.alu_valid = 1'b0;
    tick();
    check_wr("bp_drain10", 5'd10, 32'hA0A0);
    check("bp_pending_10", bus.pending, 32'h1800);
    check("bp_ready_again", {31'd0, bus.ld_rsp_ready}, 32'd1);
    tick();
    bus.ld_rsp_valid = 1'b0;
    check_wr("bp_drain11", 5'd11, 32'hB1B1);
    check("bp_pending_11", bus.pending, 32'h1000);
    tick();
    check_wr("bp_drain12", 5'd12, 32'hC2C2);
    check("bp_pending_12", bus.pending, 32'd0);
    tick();
    check_nowr("bp_done");

    // Re-issue to x9 in the cycle its older load writes: set wins
    issue(5'd9);
    tick();
    idle();
    check("x9_pending", bus.pending, 32'h200);
`ifdef WB_BYPASS_EN
    rsp(5'd9, 32'h99);
    issue(5'd9);
    tick();
    idle();
`else
    rsp(5'd9, 32'h99);
    tick();
    bus.ld_rsp_valid = 1'b0;
    check_nowr("x9_queued");
    issue(5'd9);
    tick();
    idle();
`endif
    check_wr("x9_first", 5'd9, 32'h99);
    check("x9_set_wins", bus.pending, 32'h200);
    load_rsp(5'd9, 32'h98);
    check_wr("x9_second", 5'd9, 32'h98);
    check("x9_cleared", bus.pending, 32'd0);

    // x0 writes from both sources are dropped; the load still pops
    alu(5'd0, 32'h55);
    tick();
    idle();
    check_nowr("alu_x0");
    issue(5'd0);
    tick();
    idle();
    check("x0_pending", bus.pending, 32'd0);
    load_rsp(5'd0, 32'h77);
    check_nowr("ld_x0");
    tick();
    check_nowr("ld_x0_after");
    issue(5'd3);
    tick();
    idle();
    check("x3_pending", bus.pending, 32'h8);
    load_rsp(5'd3, 32'h33);
    check_wr("x3_after_x0", 5'd3, 32'h33);
    check("x3_cleared", bus.pending, 32'd0);
    tick();

    // Mid-operation reset with a full FIFO and pending = 0x180
    issue(5'd7);
    tick();
    issue(5'd8);
    tick();
    idle();
    alu(5'd30, 32'h300);
    rsp(5'd7, 32'h70);
    tick();
    alu(5'd31, 32'h310);
    rsp(5'd8, 32'h80);
    tick();
    bus.ld_rsp_valid = 1'b0;
    check("prerst_pending", bus.pending, 32'h180);
    check("prerst_ready", {31'd0, bus.ld_rsp_ready}, 32'd0);
    check_wr("prerst_alu31", 5'd31, 32'h310);
    #3;
    reset_n = 1'b0;
    #1;
    check_nowr("rst_async");
    check("rst_async_rd",      {27'd0, bus.rf_rd}, 32'd0);
    check("rst_async_data",    bus.rf_data, 32'd0);
    check("rst_async_pending", bus.pending, 32'd0);
    check("rst_async_ready",   {31'd0, bus.ld_rsp_ready}, 32'd1);
    idle();
    #10;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_nowr("post_rst");
      check("post_rst_pending", bus.pending, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
